// File: rtl/ball_link_tx_scheduler.sv
// Sequences one 7-byte ball-state packet (address + 6 register bytes) through a byte-level I2C master.
// Latency: start 1 cycle after grant; each i2c_en 1 cycle after the preceding tx_done; pkt_done 1 cycle after ready in DRAIN.
// Backpressure: grants wait for ready; each master handshake is bounded by TIMEOUT_CYC. Optional macro TX_RETRY_EN adds one retry.
module ball_link_tx_scheduler #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h12,
  parameter int         TIMEOUT_CYC = 200000,
  parameter int         TO_W        = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ball_send_trigger,
  input  logic       is_lose,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic       is_collusion,
  input  logic       ready,
  input  logic       tx_done,
  output logic       start,
  output logic       i2c_en,
  output logic [7:0] tx_data,
  output logic       stop,
  output logic       is_transfer,
  output logic       pkt_done,
  output logic       pkt_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SEND, S_WAIT, S_STOP, S_DRAIN, S_RETRY
  } state_t;

  // The abort decision is registered, so stop/pkt_err appear in the
  // TIMEOUT_CYC-th cycle after the handshake that entered the wait state.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            pend_ball_q, pend_win_q, lose_prev_q;
  logic [9:0]      y_q;
  logic [7:0]      vy_q;
  logic [1:0]      grav_q;
  logic            coll_q, win_q;
  logic            start_q, en_q, stop_q, done_q, err_q;
  logic [7:0]      tx_data_q;
`ifdef TX_RETRY_EN
  logic            retry_q;
`endif

  logic       lose_rise, grant, timed_out, abort;
  logic       pend_ball_d, pend_win_d;
  logic [2:0] nxt_idx;
  logic [7:0] nxt_byte;

  // Request latching, arbitration, timeout detection and next-byte selection.
  always_comb begin
    lose_rise   = is_lose & ~lose_prev_q;
    grant       = (state_q == S_IDLE) && ready && (pend_win_q || pend_ball_q);
    pend_win_d  = (pend_win_q && !(grant && pend_win_q)) || lose_rise;
    pend_ball_d = (pend_ball_q && !(grant && !pend_win_q)) || ball_send_trigger;
    timed_out   = (to_cnt_q == TO_LAST);
    abort       = timed_out && (((state_q == S_WAIT) && !tx_done) ||
                                ((state_q == S_DRAIN) && !ready));
    nxt_idx     = (state_q == S_WAIT) ? idx_q + 3'd1 : 3'd0;
    case (nxt_idx)
      3'd0:    nxt_byte = {SLAVE_ADDR, 1'b0};
      3'd1:    nxt_byte = {6'b0, y_q[9:8]};
      3'd2:    nxt_byte = y_q[7:0];
      3'd3:    nxt_byte = vy_q;
      3'd4:    nxt_byte = {6'b0, grav_q};
      3'd5:    nxt_byte = {7'b0, coll_q};
      default: nxt_byte = {7'b0, win_q};
    endcase
  end

  // Packet FSM with registered pulse outputs, pending flags and snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      to_cnt_q    <= '0;
      pend_ball_q <= 1'b0;
      pend_win_q  <= 1'b0;
      lose_prev_q <= 1'b0;
      y_q         <= 10'd0;
      vy_q        <= 8'd0;
      grav_q      <= 2'd0;
      coll_q      <= 1'b0;
      win_q       <= 1'b0;
      start_q     <= 1'b0;
      en_q        <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_data_q   <= 8'd0;
`ifdef TX_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      pend_ball_q <= pend_ball_d;
      pend_win_q  <= pend_win_d;
      lose_prev_q <= is_lose;
      start_q     <= 1'b0;
      en_q        <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      if (!timed_out) to_cnt_q <= to_cnt_q + TO_W'(1);
      case (state_q)
        S_IDLE: if (grant) begin
          y_q      <= ball_y;
          vy_q     <= ball_vy;
          grav_q   <= gravity_counter;
          coll_q   <= is_collusion;
          win_q    <= pend_win_q;
          start_q  <= 1'b1;
          state_q  <= S_START;
          to_cnt_q <= '0;
        end
        S_START: begin
          idx_q     <= nxt_idx;
          tx_data_q <= nxt_byte;
          en_q      <= 1'b1;
          state_q   <= S_SEND;
          to_cnt_q  <= '0;
        end
        S_SEND: begin
          state_q  <= S_WAIT;
          to_cnt_q <= '0;
        end
        S_WAIT: if (tx_done) begin
          to_cnt_q <= '0;
          if (idx_q == 3'd6) begin
            stop_q  <= 1'b1;
            state_q <= S_STOP;
          end else begin
            idx_q     <= nxt_idx;
            tx_data_q <= nxt_byte;
            en_q      <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_STOP: begin
          state_q  <= S_DRAIN;
          to_cnt_q <= '0;
        end
        S_DRAIN: if (ready) begin
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
          to_cnt_q <= '0;
`ifdef TX_RETRY_EN
          retry_q  <= 1'b0;
`endif
        end
`ifdef TX_RETRY_EN
        S_RETRY: if (ready) begin
          start_q  <= 1'b1;
          state_q  <= S_START;
          to_cnt_q <= '0;
        end else if (timed_out) begin
          err_q    <= 1'b1;
          retry_q  <= 1'b0;
          state_q  <= S_IDLE;
          to_cnt_q <= '0;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
      // A stalled handshake releases the bus; overrides the normal transition.
      if (abort) begin
        to_cnt_q <= '0;
        stop_q   <= 1'b1;
`ifdef TX_RETRY_EN
        if (!retry_q) begin
          retry_q <= 1'b1;
          state_q <= S_RETRY;
        end else begin
          err_q   <= 1'b1;
          retry_q <= 1'b0;
          state_q <= S_IDLE;
        end
`else
        err_q   <= 1'b1;
        state_q <= S_IDLE;
`endif
      end
    end
  end

  assign start       = start_q;
  assign i2c_en      = en_q;
  assign tx_data     = tx_data_q;
  assign stop        = stop_q;
  assign pkt_done    = done_q;
  assign pkt_err     = err_q;
  assign is_transfer = (state_q != S_IDLE);

endmodule

// File: tb/tb_ball_link_tx_scheduler.sv
// Directed bench for ball_link_tx_scheduler with a behavioural I2C master model.
// The master acks each byte 20 cycles after i2c_en and releases ready 2 cycles after stop.
// Inputs change 2 time units after posedge; the master model samples on negedge.
module tb_ball_link_tx_scheduler;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ball_send_trigger = 1'b0;
  logic       is_lose = 1'b0;
  logic [9:0] ball_y = 10'd0;
  logic [7:0] ball_vy = 8'd0;
  logic [1:0] gravity_counter = 2'd0;
  logic       is_collusion = 1'b0;
  logic       ready = 1'b0;
  logic       tx_done = 1'b0;
  logic       start, i2c_en, stop, is_transfer, pkt_done, pkt_err;
  logic [7:0] tx_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit ack_en = 1'b1;
  bit hold_low = 1'b0;
  int n_start = 0, n_en = 0, n_stop = 0, n_done = 0, n_err = 0, n_done_xfer = 0;
  int start_cyc = 0, en_cyc = 0, stop_cyc = 0, err_cyc = 0, rdy_rise_cyc = 0;
  logic [7:0] bq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ball_link_tx_scheduler #(.SLAVE_ADDR(7'h12), .TIMEOUT_CYC(TO), .TO_W(18)) dut (
    .clk(clk), .reset(reset), .ball_send_trigger(ball_send_trigger), .is_lose(is_lose),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_counter(gravity_counter),
    .is_collusion(is_collusion), .ready(ready), .tx_done(tx_done), .start(start),
    .i2c_en(i2c_en), .tx_data(tx_data), .stop(stop), .is_transfer(is_transfer),
    .pkt_done(pkt_done), .pkt_err(pkt_err)
  );

  // Master model and pulse monitor.
  initial begin
    int  ack_cnt;
    int  stop_cnt;
    bit  busy;
    bit  rdy_n;
    ack_cnt = 0; stop_cnt = 0; busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0; ack_cnt = 0; stop_cnt = 0; tx_done = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) tx_done = 1'b1;
        end
        if (stop_cnt > 0) begin
          stop_cnt--;
          if (stop_cnt == 0) busy = 1'b0;
        end
        if (start) begin n_start++; start_cyc = cyc; busy = 1'b1; end
        if (i2c_en) begin
          n_en++; en_cyc = cyc; bq.push_back(tx_data);
          if (ack_en) ack_cnt = 20;
        end
        if (stop) begin n_stop++; stop_cyc = cyc; stop_cnt = 2; end
        if (pkt_done) begin n_done++; if (is_transfer) n_done_xfer++; end
        if (pkt_err) begin n_err++; err_cyc = cyc; end
      end
      rdy_n = !busy && !hold_low;
      if (rdy_n && !ready) rdy_rise_cyc = cyc;
      ready = rdy_n;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors, required completion", vectors);
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_trig();
    @(posedge clk); #2 ball_send_trigger = 1'b1;
    @(posedge clk); #2 ball_send_trigger = 1'b0;
  endtask

  task automatic set_ball(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g, input logic c);
    ball_y = y; ball_vy = vy; gravity_counter = g; is_collusion = c;
  endtask

  // Waits until a monitor counter reaches target: 0=done 1=err 2=start 3=en.
  task automatic wait_cnt(input int what, input int target, input int budget, output bit ok);
    int v;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      case (what)
        0: v = n_done;
        1: v = n_err;
        2: v = n_start;
        default: v = n_en;
      endcase
      if (v >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    tick(3);
    vectors++;
    if ({start, i2c_en, stop, is_transfer, pkt_done, pkt_err, tx_data} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required all zero", {start, i2c_en, stop, is_transfer, pkt_done, pkt_err, tx_data});
    end
    @(posedge clk); #2 reset = 1'b0;
    tick(5);
    vectors++;
    if (is_transfer !== 1'b0 || n_start != 0) begin
      miscompares++;
      $display("FAIL reset_idle: is_transfer=%b starts=%0d, required 0 and 0", is_transfer, n_start);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [7];
    int b0, s0, e0, p0, d0, r0;
    bit ok;
    exp = '{8'h24, 8'h02, 8'hA5, 8'hF3, 8'h02, 8'h01, 8'h00};
    b0 = bq.size(); s0 = n_start; e0 = n_en; p0 = n_stop; d0 = n_done; r0 = n_err;
    set_ball(10'h2A5, 8'hF3, 2'd2, 1'b1);
    pulse_trig();
    wait_cnt(0, d0 + 1, 1000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL basic_done: pkt_done not seen, required within 1000 cycles"); end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (bq[b0 + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got %h, required %h", i, bq[b0 + i], exp[i]);
      end
    end
    vectors++;
    if (n_start - s0 != 1 || n_en - e0 != 7 || n_stop - p0 != 1 || n_err != r0) begin
      miscompares++;
      $display("FAIL basic_pulses: start=%0d en=%0d stop=%0d err=%0d, required 1 7 1 0",
               n_start - s0, n_en - e0, n_stop - p0, n_err - r0);
    end
    vectors++;
    if (en_cyc != stop_cyc - 21) begin
      miscompares++;
      $display("FAIL basic_stop_latency: stop %0d cycles after last i2c_en, required 21", stop_cyc - en_cyc);
    end
  endtask

  task automatic test_win_priority();
    logic [7:0] exp [14];
    int b0, s0, d0, x0;
    bit ok;
    exp = '{8'h24, 8'h01, 8'h55, 8'h0C, 8'h01, 8'h00, 8'h01,
            8'h24, 8'h01, 8'h55, 8'h0C, 8'h01, 8'h00, 8'h00};
    b0 = bq.size(); s0 = n_start; d0 = n_done; x0 = n_done_xfer;
    set_ball(10'h155, 8'h0C, 2'd1, 1'b0);
    @(posedge clk); #2 ball_send_trigger = 1'b1; is_lose = 1'b1;
    @(posedge clk); #2 ball_send_trigger = 1'b0;
    wait_cnt(0, d0 + 2, 1500, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL win_done: two packets not completed, got %0d", n_done - d0); end
    for (int i = 0; i < 14; i++) begin
      vectors++;
      if (bq[b0 + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL win_byte%0d: got %h, required %h", i, bq[b0 + i], exp[i]);
      end
    end
    vectors++;
    if (n_start - s0 != 2 || n_done_xfer != x0) begin
      miscompares++;
      $display("FAIL win_gap: starts=%0d done_with_transfer_high=%0d, required 2 and 0", n_start - s0, n_done_xfer - x0);
    end
    is_lose = 1'b0;
    tick(5);
  endtask

  task automatic test_coalesce();
    logic [7:0] exp [14];
    int b0, s0, d0;
    bit ok;
    exp = '{8'h24, 8'h00, 8'h7E, 8'h11, 8'h00, 8'h00, 8'h00,
            8'h24, 8'h02, 8'hC3, 8'h80, 8'h03, 8'h01, 8'h00};
    b0 = bq.size(); s0 = n_start; d0 = n_done;
    set_ball(10'h07E, 8'h11, 2'd0, 1'b0);
    pulse_trig();
    wait_cnt(2, s0 + 1, 100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL coal_start: start not seen, required within 100 cycles"); end
    for (int k = 0; k < 3; k++) begin
      set_ball(10'h3FF - 10'(k), 8'hFF, 2'd1, 1'b0);
      pulse_trig();
    end
    set_ball(10'h2C3, 8'h80, 2'd3, 1'b1);
    wait_cnt(0, d0 + 2, 1500, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL coal_done: got %0d packets, required 2", n_done - d0); end
    for (int i = 0; i < 14; i++) begin
      vectors++;
      if (bq[b0 + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL coal_byte%0d: got %h, required %h", i, bq[b0 + i], exp[i]);
      end
    end
    tick(100);
    vectors++;
    if (n_start - s0 != 2) begin
      miscompares++;
      $display("FAIL coal_count: got %0d packets started, required 2", n_start - s0);
    end
  endtask

  task automatic test_timeout();
    int b0, s0, e0, p0, d0, r0;
    bit ok;
    int exp_att;
`ifdef TX_RETRY_EN
    exp_att = 2;
`else
    exp_att = 1;
`endif
    b0 = bq.size(); s0 = n_start; e0 = n_en; p0 = n_stop; d0 = n_done; r0 = n_err;
    ack_en = 1'b0;
    set_ball(10'h001, 8'h02, 2'd0, 1'b0);
    pulse_trig();
    wait_cnt(1, r0 + 1, 1000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL to_err: pkt_err not seen, required within 1000 cycles"); end
    vectors++;
    if (err_cyc - en_cyc != TO) begin
      miscompares++;
      $display("FAIL to_latency: pkt_err %0d cycles after i2c_en, required %0d", err_cyc - en_cyc, TO);
    end
    vectors++;
    if (stop_cyc != err_cyc) begin
      miscompares++;
      $display("FAIL to_stop_with_err: stop at %0d err at %0d, required equal", stop_cyc, err_cyc);
    end
    vectors++;
    if (n_start - s0 != exp_att || n_en - e0 != exp_att || n_stop - p0 != exp_att || n_done != d0) begin
      miscompares++;
      $display("FAIL to_pulses: start=%0d en=%0d stop=%0d done=%0d, required %0d %0d %0d 0",
               n_start - s0, n_en - e0, n_stop - p0, n_done - d0, exp_att, exp_att, exp_att);
    end
    for (int i = 0; i < exp_att; i++) begin
      vectors++;
      if (bq[b0 + i] !== 8'h24) begin
        miscompares++;
        $display("FAIL to_byte%0d: got %h, required 24", i, bq[b0 + i]);
      end
    end
    tick(2);
    vectors++;
    if (is_transfer !== 1'b0) begin
      miscompares++;
      $display("FAIL to_idle: is_transfer=%b, required 0", is_transfer);
    end
    ack_en = 1'b1;
    tick(5);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [7];
    int e0, s0, b0, d0;
    bit ok;
    exp = '{8'h24, 8'h03, 8'hC0, 8'h5A, 8'h03, 8'h00, 8'h00};
    e0 = n_en; s0 = n_start;
    set_ball(10'h0F0, 8'h9D, 2'd1, 1'b1);
    pulse_trig();
    wait_cnt(3, e0 + 4, 500, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rmid_byte3: fourth i2c_en not seen, required within 500 cycles"); end
    pulse_trig();
    tick(3);
    vectors++;
    if (is_transfer !== 1'b1 || tx_data !== 8'h9D) begin
      miscompares++;
      $display("FAIL rmid_pre: is_transfer=%b tx_data=%h, required 1 and 9d", is_transfer, tx_data);
    end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    vectors++;
    if ({start, i2c_en, stop, is_transfer, pkt_done, pkt_err, tx_data} !== 14'd0) begin
      miscompares++;
      $display("FAIL rmid_outputs: got %b, required all zero", {start, i2c_en, stop, is_transfer, pkt_done, pkt_err, tx_data});
    end
    tick(2);
    reset = 1'b0;
    s0 = n_start;
    tick(40);
    vectors++;
    if (n_start != s0) begin
      miscompares++;
      $display("FAIL rmid_pend_cleared: got %0d starts after reset, required 0", n_start - s0);
    end
    b0 = bq.size(); d0 = n_done;
    set_ball(10'h3C0, 8'h5A, 2'd3, 1'b0);
    pulse_trig();
    wait_cnt(0, d0 + 1, 1000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rmid_done: pkt_done not seen after reset, required within 1000 cycles"); end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (bq[b0 + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL rmid_byte%0d: got %h, required %h", i, bq[b0 + i], exp[i]);
      end
    end
  endtask

  task automatic test_ready_low();
    int s0, d0;
    bit ok;
    s0 = n_start; d0 = n_done;
    @(posedge clk); #2 hold_low = 1'b1;
    set_ball(10'h100, 8'h01, 2'd0, 1'b1);
    pulse_trig();
    tick(30);
    vectors++;
    if (n_start != s0 || is_transfer !== 1'b0) begin
      miscompares++;
      $display("FAIL rdy_block: starts=%0d is_transfer=%b, required 0 and 0", n_start - s0, is_transfer);
    end
    hold_low = 1'b0;
    wait_cnt(2, s0 + 1, 100, ok);
    vectors++;
    if (!ok || start_cyc != rdy_rise_cyc + 1) begin
      miscompares++;
      $display("FAIL rdy_latency: start %0d cycles after ready rose, required 1", start_cyc - rdy_rise_cyc);
    end
    wait_cnt(0, d0 + 1, 1000, ok);
    vectors++;
    if (!ok || bq[bq.size() - 2] !== 8'h01) begin
      miscompares++;
      $display("FAIL rdy_packet: done=%0d coll byte=%h, required 1 and 01", n_done - d0, bq[bq.size() - 2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_win_priority();
    test_coalesce();
    test_timeout();
    test_reset_mid();
    test_ready_low();
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ball_link_tx_scheduler.md
Name: ball_link_tx_scheduler

Overview:
- Sequences the byte-level I2C master to send one 7-byte ball-state packet to the peer board.
- Packet: address byte plus six register bytes.
- Arbitrates between two requesters, periodic ball updates and the lose/win notification, latching and coalescing requests that arrive while a transfer is in flight.
- Sits between the game/ball logic and the I2C master, and replaces ad-hoc start/stop pulsing.

Parameters:
- SLAVE_ADDR, 7'h12, 7-bit peer address; address byte = {SLAVE_ADDR, 1'b0} (write).
- TIMEOUT_CYC, 200000, max clk cycles waiting for any single master handshake before abort.
- TO_W, 18, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- ball_send_trigger, input, 1, one-cycle request for a ball-state packet
- is_lose, input, 1, level; rising edge requests a win-flag packet
- ball_y, input, 10, ball Y position
- ball_vy, input, 8, ball Y velocity
- gravity_counter, input, 2, gravity phase
- is_collusion, input, 1, paddle collision flag
- ready, input, 1, master idle, bus released
- tx_done, input, 1, one-cycle pulse: current byte (incl. ACK slot) complete
- start, output, 1, one-cycle pulse: master issues START
- i2c_en, output, 1, one-cycle pulse: master loads tx_data and shifts it out
- tx_data, output, 8, byte to transmit
- stop, output, 1, one-cycle pulse: master issues STOP
- is_transfer, output, 1, high from grant until return to IDLE
- pkt_done, output, 1, one-cycle pulse on successful completion
- pkt_err, output, 1, one-cycle pulse on timeout abort

Behaviour:
- Reset (async): state IDLE; all outputs 0; pending flags, snapshot, counters cleared.
- Request latching:
  - pend_ball sets on ball_send_trigger.
  - pend_win sets on the is_lose rising edge (registered previous value).
  - Both latch in any state.
  - Repeated requests while pending coalesce into one.
- Arbitration in IDLE with ready=1: pend_win has priority over pend_ball.
- Grant cycle:
  - Snapshot ball_y, ball_vy, gravity_counter, is_collusion.
  - win_bit = 1 if the win request was granted, else 0.
  - Clear only the granted pending flag.
  - A request arriving in the grant cycle itself stays pending.
- Packet bytes, in order:
  - B0 = {SLAVE_ADDR, 0}
  - B1 = {6'b0, y[9:8]}
  - B2 = y[7:0]
  - B3 = vy
  - B4 = {6'b0, grav}
  - B5 = {7'b0, coll}
  - B6 = {7'b0, win_bit}
- FSM:
  - IDLE -> START: on grant.
  - START: pulse start one cycle, byte index=0 -> SEND.
  - SEND: pulse i2c_en one cycle; tx_data = byte[index], held stable until the next SEND -> WAIT.
  - WAIT: on tx_done, if index==6 -> STOP, else index++ -> SEND.
  - STOP: pulse stop one cycle -> DRAIN.
  - DRAIN: wait for ready=1, then pulse pkt_done -> IDLE.
- Latency: start asserts 1 cycle after grant; each i2c_en asserts 1 cycle after the preceding tx_done.
- is_transfer = (state != IDLE).
- A new grant may occur in the cycle after return to IDLE if a request is pending and ready=1.
- Timeout:
  - Counter clears on every state change.
  - If WAIT or DRAIN stays TIMEOUT_CYC cycles -> pulse stop and pkt_err together -> IDLE.
  - Abort does not clear the pending flags of other requesters.
- tx_done arriving outside WAIT is ignored.
- ready low in IDLE blocks grants; requests stay pending.
- Reset mid-packet: immediate return to IDLE, no stop issued; the master is reset by the same signal.

Optional Feature:
- Macro TX_RETRY_EN.
- When defined:
  - On timeout, if the retry bit is clear: pulse stop, set the retry bit, wait for ready, then restart at START with the same snapshot; no pkt_err.
  - A second timeout pulses pkt_err and goes to IDLE.
  - The retry bit clears on pkt_done or pkt_err.
- When undefined: the first timeout aborts as described in Behaviour.

Test Plan:
- ball_y=10'h2A5, vy=8'hF3, grav=2, coll=1; trigger; master model acks each byte after 20 cycles -> bytes 24,02,A5,F3,02,01,00; one start, seven i2c_en, one stop, then pkt_done.
- is_lose rises and trigger fires in the same cycle -> win packet first (B6=01), ball packet next; is_transfer low for at least 1 cycle between them.
- Three triggers during an active packet -> exactly one extra packet follows, carrying ball values sampled at its grant.
- Master never pulses tx_done, TIMEOUT_CYC=50 -> stop and pkt_err pulse 50 cycles after the first i2c_en; FSM returns to IDLE. With TX_RETRY_EN: one restart with identical bytes, then pkt_err.
- Reset asserted while waiting on byte 3 -> all outputs 0 in the same cycle; after release a fresh trigger sends a full packet.
- ready held low with trigger pending -> no start; start asserts 1 cycle after ready rises.
